box_overlay: RTL and testbench

- Draws a rectangle onto the RGB888 video stream, using the frame bounding box (box_flag, top/bottom/left/right edges) produced by the frame-difference box detector.
- Sits after the detector, on the display path.
- Frame N's box is drawn on frame N+1.
- Pixel coordinates come from an h/v counter bit-identical to the detector's, so edge values line up pixel-exact.

---
 rtl/box_overlay_pkg.sv | 32 +++
 rtl/box_overlay_if.sv | 39 +++
 rtl/box_overlay_frame_coord_cnt.sv | 60 ++++++
 rtl/box_overlay.sv | 124 ++++++++++++
 tb/tb_box_overlay.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/box_overlay_pkg.sv
// Shared definitions for the box detector / box overlay display path:
// default video timing, coordinate and pixel widths, and the box record.
package box_overlay_pkg;

    localparam int unsigned H_TOTAL_DEF = 1650;
    localparam int unsigned V_TOTAL_DEF = 750;
    localparam int unsigned COORD_W     = 11;
    localparam int unsigned RGB_W       = 24;
    // One extra bit so edge +/- border arithmetic never wraps.
    localparam int unsigned CALC_W      = COORD_W + 1;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CALC_W-1:0]  calc_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    typedef struct packed {
        coord_t top;
        coord_t bottom;
        coord_t left;
        coord_t right;
    } box_t;

    function automatic calc_t widen(input coord_t c);
        return {1'b0, c};
    endfunction

    // A box is drawable only if its edges are ordered.
    function automatic logic box_ordered(input box_t b);
        return (b.right >= b.left) && (b.bottom >= b.top);
    endfunction

endpackage

// File: rtl/box_overlay_if.sv
// RGB888 video stream in/out of the overlay: input sync/valid/data from the
// upstream source and the delayed, box-drawn stream towards the display.
interface box_overlay_if;
    import box_overlay_pkg::*;

    logic pre_img_vsync;
    logic pre_img_hsync;
    logic pre_img_valid;
    rgb_t pre_img_data;
    logic post_img_vsync;
    logic post_img_hsync;
    logic post_img_valid;
    rgb_t post_img_data;

    // Source/sink side: drives the input stream, observes the output stream.
    modport master (
        output pre_img_vsync,
        output pre_img_hsync,
        output pre_img_valid,
        output pre_img_data,
        input  post_img_vsync,
        input  post_img_hsync,
        input  post_img_valid,
        input  post_img_data
    );

    // Overlay side: consumes the input stream, produces the output stream.
    modport slave (
        input  pre_img_vsync,
        input  pre_img_hsync,
        input  pre_img_valid,
        input  pre_img_data,
        output post_img_vsync,
        output post_img_hsync,
        output post_img_valid,
        output post_img_data
    );

endinterface

// File: rtl/box_overlay_frame_coord_cnt.sv
// Frame coordinate counter shared with the box detector: vsync rising-edge
// detect plus an h/v counter that starts on each vsync rise and stops after
// one full frame, so both blocks see bit-identical pixel coordinates.
module frame_coord_cnt
    import box_overlay_pkg::*;
#(
    parameter int unsigned H_TOTAL = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   vsync,
    output logic   pos_vs,
    output coord_t h_cnt,
    output coord_t v_cnt,
    output logic   run_flag
);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    logic vsync_d;

    // Registered copy of vsync for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync;
        end
    end

    assign pos_vs = vsync & ~vsync_d;

    // Restart at (0,0) on every vsync rise; run one frame, then halt at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            run_flag <= 1'b0;
        end else if (pos_vs) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            run_flag <= 1'b1;
        end else if (run_flag) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt    <= '0;
                    run_flag <= 1'b0;
                end else begin
                    v_cnt <= v_cnt + coord_t'(1);
                end
            end else begin
                h_cnt <= h_cnt + coord_t'(1);
            end
        end
    end

endmodule

// File: rtl/box_overlay.sv
// Box overlay: paints the previous frame's detector bounding box onto the
// RGB888 display stream as a LINE_W-thick border, with a fixed 2-cycle latency.
module box_overlay
    import box_overlay_pkg::*;
#(
    parameter int unsigned H_TOTAL   = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL   = V_TOTAL_DEF,
    parameter int unsigned LINE_W    = 2,
    parameter rgb_t        BOX_COLOR = 24'hFF0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         overlay_en,
    input  logic         box_flag,
    input  coord_t       top_edge,
    input  coord_t       bottom_edge,
    input  coord_t       left_edge,
    input  coord_t       right_edge,
    box_overlay_if.slave vid
);

    localparam calc_t LW = calc_t'(LINE_W);

    logic   pos_vs;
    coord_t h_cnt;
    coord_t v_cnt;
    logic   unused_run_flag;

    frame_coord_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_coord (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync    (vid.pre_img_vsync),
        .pos_vs   (pos_vs),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .run_flag (unused_run_flag)
    );

    box_t box_in;
    box_t box_q;
    logic box_en_q;

    assign box_in.top    = top_edge;
    assign box_in.bottom = bottom_edge;
    assign box_in.left   = left_edge;
    assign box_in.right  = right_edge;

    // Shadow copy of the box, taken only at frame start so mid-frame detector
    // updates cannot tear the border; reset leaves the box disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_q    <= '0;
            box_en_q <= 1'b0;
        end else if (pos_vs) begin
            box_q    <= box_in;
            box_en_q <= box_flag & overlay_en & box_ordered(box_in);
        end
    end

    calc_t h_w, v_w, top_w, bot_w, left_w, right_w;
    logic  in_h, in_v, near_h, near_v, hit;

    // Border hit test for the pixel currently at the input.
    always_comb begin
        h_w     = widen(h_cnt);
        v_w     = widen(v_cnt);
        top_w   = widen(box_q.top);
        bot_w   = widen(box_q.bottom);
        left_w  = widen(box_q.left);
        right_w = widen(box_q.right);
        in_h    = (h_w >= left_w) && (h_w <= right_w);
        in_v    = (v_w >= top_w) && (v_w <= bot_w);
        near_h  = (h_w < left_w + LW) || (h_w + LW > right_w);
        near_v  = (v_w < top_w + LW) || (v_w + LW > bot_w);
        hit     = box_en_q & in_h & in_v & (near_h | near_v);
    end

    logic s1_vsync, s1_hsync, s1_valid, s1_hit;
    rgb_t s1_data;

    // Stage 1: register the stream together with its hit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vsync <= 1'b0;
            s1_hsync <= 1'b0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_hit   <= 1'b0;
        end else begin
            s1_vsync <= vid.pre_img_vsync;
            s1_hsync <= vid.pre_img_hsync;
            s1_valid <= vid.pre_img_valid;
            s1_data  <= vid.pre_img_data;
            s1_hit   <= hit;
        end
    end

    logic post_vsync_q, post_hsync_q, post_valid_q;
    rgb_t post_data_q;

    // Stage 2: substitute the border colour on active hit pixels only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vsync_q <= 1'b0;
            post_hsync_q <= 1'b0;
            post_valid_q <= 1'b0;
            post_data_q  <= '0;
        end else begin
            post_vsync_q <= s1_vsync;
            post_hsync_q <= s1_hsync;
            post_valid_q <= s1_valid;
            post_data_q  <= (s1_hit & s1_valid) ? BOX_COLOR : s1_data;
        end
    end

    assign vid.post_img_vsync = post_vsync_q;
    assign vid.post_img_hsync = post_hsync_q;
    assign vid.post_img_valid = post_valid_q;
    assign vid.post_img_data  = post_data_q;

endmodule

// File: tb/tb_box_overlay.sv
// Bench for box_overlay: two instances (border 1 and 2 pixels) on a small
// 32x24 raster, checked every cycle against a coordinate-level model, plus
// literal expectations at hand-picked pixels.
module tb_box_overlay;
    import box_overlay_pkg::*;

    localparam int H  = 32;
    localparam int V  = 24;
    localparam int NF = 7;
    localparam logic [23:0] COLOR = 24'hFF0000;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        val;
        logic [23:0] d1;
        logic [23:0] d2;
        bit          tag;
        int          f;
        int          v;
        int          h;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    logic   overlay_en = 1'b1;
    logic   box_flag = 1'b0;
    coord_t top_e = 11'd4;
    coord_t bot_e = 11'd8;
    coord_t left_e = 11'd10;
    coord_t right_e = 11'd20;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q[$];
    int m_en = 0, m_t = 0, m_b = 0, m_l = 0, m_r = 0;
    logic [23:0] obs1 [NF][H*V];
    logic [23:0] obs2 [NF][H*V];

    box_overlay_if vid1 ();
    box_overlay_if vid2 ();

    assign vid2.pre_img_vsync = vid1.pre_img_vsync;
    assign vid2.pre_img_hsync = vid1.pre_img_hsync;
    assign vid2.pre_img_valid = vid1.pre_img_valid;
    assign vid2.pre_img_data  = vid1.pre_img_data;

    box_overlay #(.H_TOTAL(H), .V_TOTAL(V), .LINE_W(1), .BOX_COLOR(COLOR)) dut1 (
        .clk(clk), .rst_n(rst_n), .overlay_en(overlay_en), .box_flag(box_flag),
        .top_edge(top_e), .bottom_edge(bot_e), .left_edge(left_e), .right_edge(right_e),
        .vid(vid1)
    );

    box_overlay #(.H_TOTAL(H), .V_TOTAL(V), .LINE_W(2), .BOX_COLOR(COLOR)) dut2 (
        .clk(clk), .rst_n(rst_n), .overlay_en(overlay_en), .box_flag(box_flag),
        .top_edge(top_e), .bottom_edge(bot_e), .left_edge(left_e), .right_edge(right_e),
        .vid(vid2)
    );

    always #5 clk = ~clk;

    // Is pixel (v,h) on the border of box [t..b]x[l..r] of thickness lw?
    function automatic bit model_hit(input int lw, input int en, input int t, input int b,
                                     input int l, input int r, input int v, input int h);
        if (en == 0) return 1'b0;
        if (h < l || h > r || v < t || v > b) return 1'b0;
        return (h < l + lw) || (h > r - lw) || (v < t + lw) || (v > b - lw);
    endfunction

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_zero();
        exp_t z;
        z.vs = 1'b0; z.hs = 1'b0; z.val = 1'b0; z.d1 = '0; z.d2 = '0;
        z.tag = 1'b0; z.f = 0; z.v = 0; z.h = 0;
        q.push_back(z);
    endtask

    task automatic drive(input logic vs, input logic hs, input logic val, input logic [23:0] d,
                         input bit tag, input int f, input int v, input int h);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        vid1.pre_img_vsync = vs;
        vid1.pre_img_hsync = hs;
        vid1.pre_img_valid = val;
        vid1.pre_img_data  = d;
        e.vs = vs; e.hs = hs; e.val = val; e.tag = tag; e.f = f; e.v = v; e.h = h;
        e.d1 = (val && tag && model_hit(1, m_en, m_t, m_b, m_l, m_r, v, h)) ? COLOR : d;
        e.d2 = (val && tag && model_hit(2, m_en, m_t, m_b, m_l, m_r, v, h)) ? COLOR : d;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset dut1", {vid1.post_img_vsync, vid1.post_img_hsync,
              vid1.post_img_valid, vid1.post_img_data}, 27'd0);
        check("async reset dut2", {vid2.post_img_vsync, vid2.post_img_hsync,
              vid2.post_img_valid, vid2.post_img_data}, 27'd0);
        q.delete();
        push_zero();
        push_zero();
        m_en = 0;
        @(posedge clk);
    endtask

    // One vsync-rise cycle, then H*V pixels; optional reset / edge change /
    // enable change at pixel index k (negative = never).
    task automatic run_frame(input int f, input int rst_k, input int chg_k, input int en_k);
        drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, f, 0, 0);
        m_en = (box_flag && overlay_en && right_e >= left_e && bot_e >= top_e) ? 1 : 0;
        m_t = int'(top_e); m_b = int'(bot_e); m_l = int'(left_e); m_r = int'(right_e);
        for (int k = 0; k < H * V; k++) begin
            int v;
            int h;
            v = k / H;
            h = k % H;
            if (k == rst_k) do_reset();
            if (k == chg_k) begin
                top_e = 11'd0;
                bot_e = 11'd2;
            end
            if (k == en_k) overlay_en = 1'b1;
            drive(k < 3, h < 2, (h >= 2) && (h < 30), 24'(f * 65536 + v * 256 + h),
                  1'b1, f, v, h);
        end
    endtask

    task automatic lit(input string name, input int dut, input int f, input int v, input int h,
                       input logic [23:0] exp);
        logic [23:0] act;
        act = (dut == 1) ? obs1[f][v * H + h] : obs2[f][v * H + h];
        check(name, {3'b0, act}, {3'b0, exp});
    endtask

    // Every cycle out of reset: both DUT outputs against the model entry that
    // was driven two clocks earlier.
    initial begin : compare
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && q.size() >= 2) begin
                while (q.size() > 2) void'(q.pop_front());
                e = q[0];
                check("stream dut1", {vid1.post_img_vsync, vid1.post_img_hsync,
                      vid1.post_img_valid, vid1.post_img_data}, {e.vs, e.hs, e.val, e.d1});
                check("stream dut2", {vid2.post_img_vsync, vid2.post_img_hsync,
                      vid2.post_img_valid, vid2.post_img_data}, {e.vs, e.hs, e.val, e.d2});
                if (e.tag) begin
                    obs1[e.f][e.v * H + e.h] = vid1.post_img_data;
                    obs2[e.f][e.v * H + e.h] = vid2.post_img_data;
                end
            end
        end
    end

    initial begin : main
        vid1.pre_img_vsync = 1'b0;
        vid1.pre_img_hsync = 1'b0;
        vid1.pre_img_valid = 1'b0;
        vid1.pre_img_data  = 24'h0;
        push_zero();
        push_zero();
        #1 rst_n = 1'b0;
        #2;
        check("reset dut1", {vid1.post_img_vsync, vid1.post_img_hsync,
              vid1.post_img_valid, vid1.post_img_data}, 27'd0);
        check("reset dut2", {vid2.post_img_vsync, vid2.post_img_hsync,
              vid2.post_img_valid, vid2.post_img_data}, 27'd0);
        repeat (2) @(posedge clk);

        check("model pin top", 27'(model_hit(1, 1, 4, 8, 10, 20, 4, 15)), 27'd1);
        check("model pin inside", 27'(model_hit(1, 1, 4, 8, 10, 20, 6, 15)), 27'd0);
        check("model pin lw2 col", 27'(model_hit(2, 1, 4, 8, 10, 20, 6, 11)), 27'd1);
        check("model pin lw2 in", 27'(model_hit(2, 1, 4, 8, 10, 20, 6, 12)), 27'd0);
        check("model pin disabled", 27'(model_hit(1, 0, 4, 8, 10, 20, 4, 15)), 27'd0);

        run_frame(0, -1, -1, -1);               // box_flag=0: pass-through
        box_flag = 1'b1;
        run_frame(1, -1, 10 * H, -1);           // 4/8/10/20, edges move mid-frame
        run_frame(2, -1, -1, -1);               // 0/2/10/20 now in effect
        top_e = 11'd4; bot_e = 11'd8; right_e = 11'd5;
        run_frame(3, -1, -1, -1);               // right < left: disabled
        right_e = 11'd20; overlay_en = 1'b0;
        run_frame(4, -1, -1, H);                // overlay_en=0 at frame start
        run_frame(5, 6 * H + 12, -1, -1);       // reset mid-frame
        run_frame(6, -1, -1, -1);               // recovers
        repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 0, 0);

        lit("f0 passthru", 1, 0, 4, 15, 24'h00040F);
        lit("f1 top row", 1, 1, 4, 15, COLOR);
        lit("f1 left col", 1, 1, 6, 10, COLOR);
        lit("f1 bot-right", 1, 1, 8, 20, COLOR);
        lit("f1 interior", 1, 1, 6, 15, 24'h01060F);
        lit("f1 above", 1, 1, 3, 15, 24'h01030F);
        lit("f1 right of", 1, 1, 6, 21, 24'h010615);
        lit("f1 old row 1", 1, 1, 1, 15, 24'h01010F);
        lit("f1 lw2 row 5", 2, 1, 5, 15, COLOR);
        lit("f1 lw2 col 11", 2, 1, 6, 11, COLOR);
        lit("f1 lw2 interior", 2, 1, 6, 12, 24'h01060C);
        lit("f2 new top", 1, 2, 0, 15, COLOR);
        lit("f2 new middle", 1, 2, 1, 15, 24'h02010F);
        lit("f2 new bottom", 1, 2, 2, 15, COLOR);
        lit("f2 old top gone", 1, 2, 4, 15, 24'h02040F);
        lit("f3 unordered", 1, 3, 4, 10, 24'h03040A);
        lit("f3 unordered b", 1, 3, 6, 10, 24'h03060A);
        lit("f3 unordered lw2", 2, 3, 4, 15, 24'h03040F);
        lit("f4 en off", 1, 4, 4, 15, 24'h04040F);
        lit("f4 en off b", 1, 4, 8, 20, 24'h040814);
        lit("f5 before reset", 1, 5, 4, 15, COLOR);
        lit("f5 after reset", 1, 5, 6, 20, 24'h050614);
        lit("f5 after reset b", 1, 5, 8, 20, 24'h050814);
        lit("f6 recovered", 1, 6, 4, 15, COLOR);
        lit("f6 recovered b", 1, 6, 8, 20, COLOR);
        lit("f6 recovered lw2", 2, 6, 5, 15, COLOR);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
